wm_embed: RTL

Pixel-stream watermark embedder sitting directly downstream of `wm_mem`. Accepts beats of `DOP` pixels, requests one `DOP`-bit watermark slice from `wm_mem` per accepted beat through its read strobe, and replaces the LSB of each pixel lane with the matching watermark bit. Output is a buffered valid/ready stream. At frame end the block issues the `done` pulse that rewinds `wm_mem`.

---
 rtl/wm_embed_if.sv | 41 ++++
 rtl/wm_embed.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wm_embed_if.sv
// wm_embed_if: bundle of the wm_embed stream and watermark-memory signals.
//   Upstream pixel stream : i_valid, o_ready, i_pix (plus i_bypass when
//                           WM_EMBED_BYPASS_EN is defined)
//   wm_mem side           : o_wm_rea (read strobe), i_wm_data, o_wm_done
//   Downstream stream     : o_valid, i_ready, o_pix, o_last
// Signal names keep the embedder's point of view (i_* driven into the block,
// o_* driven by it). Modport slave is the embedder; master is its environment.
interface wm_embed_if #(
  parameter int DOP   = 4,
  parameter int PIX_W = 8
);
  logic                 i_valid;
  logic                 o_ready;
  logic [DOP*PIX_W-1:0] i_pix;
`ifdef WM_EMBED_BYPASS_EN
  logic                 i_bypass;
`endif
  logic                 o_wm_rea;
  logic [DOP-1:0]       i_wm_data;
  logic                 o_wm_done;
  logic                 o_valid;
  logic                 i_ready;
  logic [DOP*PIX_W-1:0] o_pix;
  logic                 o_last;

  modport slave (
`ifdef WM_EMBED_BYPASS_EN
    input  i_bypass,
`endif
    input  i_valid, i_pix, i_wm_data, i_ready,
    output o_ready, o_wm_rea, o_wm_done, o_valid, o_pix, o_last
  );

  modport master (
`ifdef WM_EMBED_BYPASS_EN
    output i_bypass,
`endif
    output i_valid, i_pix, i_wm_data, i_ready,
    input  o_ready, o_wm_rea, o_wm_done, o_valid, o_pix, o_last
  );
endinterface

// File: rtl/wm_embed.sv
// wm_embed: pixel-stream watermark embedder downstream of wm_mem.
// Each accepted beat of DOP pixel lanes issues one read strobe to wm_mem; the
// beat travels through a WM_LAT-deep tagged delay line so it meets its
// watermark slice, then the LSB of every lane is replaced by the matching
// watermark bit and the result is pushed into a small output FIFO.
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - wm_embed_if.slave (input stream, wm_mem strobe/data/done,
//          output stream with o_last on the final beat of a frame)
//
// Handshake: a beat moves on a channel in every cycle where its valid and
// ready are both high at the rising edge. o_ready depends only on internal
// state (never on i_valid); o_valid/o_pix/o_last hold stable while
// o_valid && !i_ready.
//
// Optional feature: define WM_EMBED_BYPASS_EN to add i_bypass; a beat
// accepted with i_bypass=1 leaves the block unmodified (its wm_mem strobe is
// still issued so the watermark sequence stays aligned).
module wm_embed #(
  parameter int DOP         = 4,
  parameter int PIX_W       = 8,
  parameter int FRAME_BEATS = 10016,
  parameter int WM_LAT      = 2,
  parameter int OBUF_DEPTH  = 4
) (
  input logic     clk,
  input logic     rst,
  wm_embed_if.slave bus
);

  localparam int PIX_BUS_W = DOP * PIX_W;
  localparam int CNT_W     = $clog2(FRAME_BEATS);
  localparam int PTR_W     = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int OCC_W     = $clog2(OBUF_DEPTH + 1);
  localparam int INF_W     = $clog2(WM_LAT + 1);

  typedef struct packed {
    logic                 vld;
    logic                 last;
    logic                 byp;
    logic [PIX_BUS_W-1:0] pix;
  } tag_t;

  tag_t [WM_LAT-1:0]                sr_q, sr_d;
  logic [CNT_W-1:0]                 beat_cnt_q, beat_cnt_d;
  logic                             done_hold_q, done_hold_d;
  logic                             done_q, done_d;
  logic [OBUF_DEPTH-1:0][PIX_BUS_W:0] mem_q, mem_d;
  logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]                 cnt_q, cnt_d;

  logic [INF_W-1:0]                 inflight;
  logic                             ready;
  logic                             acc;
  logic                             is_last;
  logic                             byp_in;
  tag_t                             head_tag;
  logic                             wr_en;
  logic [PIX_BUS_W-1:0]             wr_pix;
  logic                             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef WM_EMBED_BYPASS_EN
  assign byp_in = bus.i_bypass;
`else
  assign byp_in = 1'b0;
`endif

  // Credit: every beat in the delay line already owns a buffer slot because
  // the buffer write cannot be stalled once its watermark data arrives.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < WM_LAT; i++) begin
      inflight = inflight + INF_W'(sr_q[i].vld);
    end
    ready   = !rst && !done_hold_q &&
              ((int'(cnt_q) + int'(inflight)) < OBUF_DEPTH);
    acc     = bus.i_valid && ready;
    is_last = (beat_cnt_q == CNT_W'(FRAME_BEATS - 1));
  end

  // Tagged delay line, aligned with the wm_mem read latency.
  always_comb begin
    sr_d        = sr_q;
    sr_d[0].vld  = acc;
    sr_d[0].last = acc && is_last;
    sr_d[0].byp  = byp_in;
    sr_d[0].pix  = bus.i_pix;
    for (int i = 1; i < WM_LAT; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Embedding: the LSB of lane k sits at bit k*PIX_W of the bus.
  always_comb begin
    head_tag = sr_q[WM_LAT-1];
    wr_en    = head_tag.vld;
    wr_pix   = head_tag.pix;
    if (!head_tag.byp) begin
      for (int k = 0; k < DOP; k++) begin
        wr_pix[k*PIX_W] = bus.i_wm_data[k];
      end
    end
  end

  // Output FIFO. Pop only sees registered occupancy, so a beat written into
  // an empty buffer is presented one cycle later.
  always_comb begin
    pop      = (cnt_q != '0) && bus.i_ready;
    mem_d    = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = {head_tag.last, wr_pix};
    end
    wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop   ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en && !pop) begin
      cnt_d = cnt_q + OCC_W'(1);
    end else if (!wr_en && pop) begin
      cnt_d = cnt_q - OCC_W'(1);
    end
  end

  // Frame tracking. done_hold blocks new accepts from the last accept of a
  // frame through the o_wm_done cycle, so wm_mem rewinds before the next
  // frame's first strobe.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (acc) begin
      beat_cnt_d = is_last ? '0 : beat_cnt_q + CNT_W'(1);
    end
    done_d      = wr_en && head_tag.last;
    done_hold_d = done_hold_q;
    if (done_q) begin
      done_hold_d = 1'b0;
    end else if (acc && is_last) begin
      done_hold_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q        <= '0;
      beat_cnt_q  <= '0;
      done_hold_q <= 1'b0;
      done_q      <= 1'b0;
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      sr_q        <= sr_d;
      beat_cnt_q  <= beat_cnt_d;
      done_hold_q <= done_hold_d;
      done_q      <= done_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_wm_rea  = acc;
  assign bus.o_wm_done = done_q;
  assign bus.o_valid   = (cnt_q != '0);
  assign bus.o_pix     = mem_q[rd_ptr_q][PIX_BUS_W-1:0];
  assign bus.o_last    = mem_q[rd_ptr_q][PIX_BUS_W];

endmodule
